// File: rtl/systolic_sched.sv
// systolic_sched: loads weights and im2col columns, streams them row by row through a systolic array, then writes Y back.
module systolic_sched #(
  parameter int M = 9,
  parameter int N = 9,
  parameter int K = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 'h1000,
  parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 'h2000,
  parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = 'h3000,
  parameter int TIMEOUT = 256
) (
  input  logic                    clk,
  input  logic                    rst_systolic,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   mem_addr_rd,
  input  logic [DATA_WIDTH-1:0]   mem_data_rd,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr_wr,
  output logic [DATA_WIDTH-1:0]   mem_data_wr,
  output logic [DATA_WIDTH*M-1:0] X,
  output logic [DATA_WIDTH*K-1:0] W,
  output logic                    arr_rst_n,
  input  logic                    arr_done,
  input  logic [DATA_WIDTH*M*K-1:0] Y
);
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, WRITEBACK, FINISH} state_t;
  localparam int LD = N * (K + M) + 1;
  localparam int WB = M * K;
  localparam int CMAX = (LD > TIMEOUT) ? ((LD > WB) ? LD : WB) : ((TIMEOUT > WB) ? TIMEOUT : WB);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LD_LAST = CW'(LD - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(N - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WB_LAST = CW'(WB - 1);
  localparam logic [CW-1:0] NK = CW'(N * K);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cap;
  logic err_q, err_d, y_cap, w_we, x_we;
  logic [DATA_WIDTH*N*K-1:0] w_buf_q;
  logic [DATA_WIDTH*N*M-1:0] x_buf_q;
  logic [DATA_WIDTH*M*K-1:0] y_q;
  always_ff @(posedge clk or negedge rst_systolic)
    if (!rst_systolic) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    err_d = err_q;
    y_cap = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = LOAD;
          err_d = 1'b0;
        end
      end
      LOAD: if (cnt_q == LD_LAST) begin
        state_d = STREAM;
        cnt_d = '0;
      end
      STREAM: if (cnt_q == ST_LAST) begin
        state_d = DRAIN;
        cnt_d = '0;
      end
      DRAIN: if (arr_done) begin
        state_d = WRITEBACK;
        cnt_d = '0;
        y_cap = 1'b1;
      end else if (cnt_q == TO_LAST) begin
        state_d = FINISH;
        cnt_d = '0;
        err_d = 1'b1;
      end
      WRITEBACK: if (cnt_q == WB_LAST) begin
        state_d = FINISH;
        cnt_d = '0;
      end
      FINISH: begin
        state_d = IDLE;
        cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Read data lags its address by one cycle, so LOAD captures the element addressed on the previous count.
  always_comb begin
    cap = cnt_q - 1'b1;
    w_we = state_q == LOAD && cnt_q != '0 && cap < NK;
    x_we = state_q == LOAD && cnt_q != '0 && cap >= NK;
    busy = state_q != IDLE;
    done = state_q == FINISH;
    err = err_q;
    arr_rst_n = state_q == STREAM || state_q == DRAIN;
    mem_addr_rd = (state_q == LOAD && cnt_q < LD_LAST) ?
                  (cnt_q < NK ? WEIGHT_BASE + ADDR_WIDTH'(cnt_q) : IM2COL_BASE + ADDR_WIDTH'(cnt_q - NK)) : '0;
    mem_wr_en = state_q == WRITEBACK;
    mem_addr_wr = mem_wr_en ? OUTPUT_BASE + ADDR_WIDTH'(cnt_q) : '0;
    mem_data_wr = mem_wr_en ? y_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    X = state_q == STREAM ? x_buf_q[cnt_q*M*DATA_WIDTH +: M*DATA_WIDTH] : '0;
    W = state_q == STREAM ? w_buf_q[cnt_q*K*DATA_WIDTH +: K*DATA_WIDTH] :
        state_q == DRAIN  ? w_buf_q[(N-1)*K*DATA_WIDTH +: K*DATA_WIDTH] : '0;
  end
  always_ff @(posedge clk) begin
    if (w_we) w_buf_q[cap*DATA_WIDTH +: DATA_WIDTH] <= mem_data_rd;
    if (x_we) x_buf_q[(cap - NK)*DATA_WIDTH +: DATA_WIDTH] <= mem_data_rd;
    if (y_cap) y_q <= Y;
  end
endmodule

// File: tb/tb_systolic_sched.sv
// tb_systolic_sched: directed checks of the scheduler with a memory model and a behavioural systolic array.
module tb_systolic_sched;
  logic clk, rst;
  logic start, busy, done, err, mem_wr_en, arr_rst_n, arr_done;
  logic [31:0] mem_addr_rd, mem_data_rd, mem_addr_wr, mem_data_wr;
  logic [287:0] X;
  logic [63:0] W;
  logic [575:0] Y;
  logic start1, busy1, done1, err1, mem_wr_en1, arr_rst_n1, arr_done1;
  logic [31:0] mem_addr_rd1, mem_data_rd1, mem_addr_wr1, mem_data_wr1, X1, W1, Y1;
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, done_cyc = 0, wr_cnt = 0, mode = 0;
  int sc, dc, wc;
  logic clr = 1'b0;
  logic [31:0] wr_mem [18];
  logic [31:0] acc [9][2];
  logic [31:0] acc1;
  int arr_cnt;

  systolic_sched u0 (.clk(clk), .rst_systolic(rst), .start(start), .busy(busy), .done(done), .err(err),
    .mem_addr_rd(mem_addr_rd), .mem_data_rd(mem_data_rd), .mem_wr_en(mem_wr_en), .mem_addr_wr(mem_addr_wr),
    .mem_data_wr(mem_data_wr), .X(X), .W(W), .arr_rst_n(arr_rst_n), .arr_done(arr_done), .Y(Y));
  systolic_sched #(.M(1), .N(1), .K(1)) u1 (.clk(clk), .rst_systolic(rst), .start(start1), .busy(busy1),
    .done(done1), .err(err1), .mem_addr_rd(mem_addr_rd1), .mem_data_rd(mem_data_rd1), .mem_wr_en(mem_wr_en1),
    .mem_addr_wr(mem_addr_wr1), .mem_data_wr(mem_data_wr1), .X(X1), .W(W1), .arr_rst_n(arr_rst_n1),
    .arr_done(arr_done1), .Y(Y1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a >= 32'h1000 && a < 32'h1012) return a - 32'hfff;
    if (a >= 32'h2000 && a < 32'h2051) return a - 32'h1fff;
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_y(input int i);
    logic [31:0] s;
    s = 0;
    for (int n = 0; n < 9; n++) s += 32'((n*9 + i/2 + 1) * (n*2 + i%2 + 1));
    return s;
  endfunction

  always @(posedge clk) begin
    mem_data_rd <= mem_val(mem_addr_rd);
    mem_data_rd1 <= mem_addr_rd1 == 32'h1000 ? 32'h7 : mem_addr_rd1 == 32'h2000 ? 32'h3 : 32'h0;
  end

  always @(posedge clk) begin
    if (!arr_rst_n) begin
      arr_cnt <= 0;
      for (int m = 0; m < 9; m++) for (int k = 0; k < 2; k++) acc[m][k] <= 0;
    end else begin
      arr_cnt <= arr_cnt + 1;
      for (int m = 0; m < 9; m++) for (int k = 0; k < 2; k++)
        acc[m][k] <= acc[m][k] + X[m*32 +: 32] * W[k*32 +: 32];
    end
    acc1 <= arr_rst_n1 ? acc1 + X1 * W1 : 32'h0;
  end
  assign arr_done = arr_rst_n && ((mode == 0 && arr_cnt == 11) || (mode == 1 && arr_cnt == 4));
  assign arr_done1 = arr_rst_n1 && X1 == 32'h0;
  assign Y1 = acc1;
  always_comb begin
    Y = '0;
    for (int m = 0; m < 9; m++) for (int k = 0; k < 2; k++) Y[(m*2 + k)*32 +: 32] = acc[m][k];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (mem_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_addr_wr >= 32'h3000 && mem_addr_wr < 32'h3012) wr_mem[int'(mem_addr_wr - 32'h3000)] <= mem_data_wr;
    end
    if (clr) for (int i = 0; i < 18; i++) wr_mem[i] <= '1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic kick();
    @(negedge clk);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    start = 1'b1;
    sc = cyc;
    dc = done_cnt;
    wc = wr_cnt;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    #2 rst = 1'b0;
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_wr", {mem_wr_en, arr_rst_n}, 0);
    chk("rst_addr", {mem_addr_rd, mem_addr_wr}, 0);
    chk("rst_xw", {63'b0, |{X, W, mem_data_wr}}, 0);
    rst = 1'b1;
    step(2);

    kick();
    step(1);
    start = 1'b0;
    chk("j1_busy", busy, 1);
    chk("j1_rd0", mem_addr_rd, 32'h1000);
    step(1);
    chk("j1_rd1", mem_addr_rd, 32'h1001);
    step(17);
    chk("j1_rd_x0", mem_addr_rd, 32'h2000);
    step(80);
    chk("j1_rd_xlast", mem_addr_rd, 32'h2050);
    step(1);
    chk("j1_capture_only", {mem_addr_rd, 31'b0, arr_rst_n}, 0);
    step(1);
    chk("j1_st0_arr", arr_rst_n, 1);
    chk("j1_st0_x", X[63:0], {32'd2, 32'd1});
    chk("j1_st0_x8", X[287:256], 32'd9);
    chk("j1_st0_w", W, {32'd2, 32'd1});
    step(8);
    chk("j1_st8_x", X[31:0], 32'd73);
    chk("j1_st8_w", W, {32'd18, 32'd17});
    step(1);
    chk("j1_dr_x", {63'b0, |X}, 0);
    chk("j1_dr_w", W, {32'd18, 32'd17});
    step(3);
    chk("j1_wb0", {mem_wr_en, mem_addr_wr}, {1'b1, 32'h3000});
    chk("j1_wb0_data", mem_data_wr, ref_y(0));
    step(17);
    chk("j1_wb17", mem_addr_wr, 32'h3011);
    chk("j1_done_early", done, 0);
    step(1);
    chk("j1_done", {done, mem_wr_en}, 2'b10);
    step(1);
    chk("j1_idle", {done, busy}, 0);
    chk("j1_latency", done_cyc - sc, 131);
    chk("j1_done_cnt", done_cnt - dc, 1);
    chk("j1_wr_cnt", wr_cnt - wc, 18);
    for (int i = 0; i < 18; i++) chk($sformatf("j1_mem%0d", i), wr_mem[i], ref_y(i));

    kick();
    step(5);
    start = 1'b0;
    step(99);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(30);
    chk("j2_done_cnt", done_cnt - dc, 1);
    chk("j2_latency", done_cyc - sc, 131);
    chk("j2_wr_cnt", wr_cnt - wc, 18);
    chk("j2_mem0", wr_mem[0], ref_y(0));
    chk("j2_mem17", wr_mem[17], ref_y(17));
    chk("j2_idle", busy, 0);

    mode = 1;
    kick();
    step(1);
    start = 1'b0;
    step(364);
    chk("j3_drain_end", {busy, done, err}, 3'b100);
    step(1);
    chk("j3_finish", {done, err}, 2'b11);
    step(1);
    chk("j3_after", {busy, done, err}, 3'b001);
    step(5);
    chk("j3_err_hold", err, 1);
    chk("j3_no_wr", wr_cnt - wc, 0);
    chk("j3_done_cnt", done_cnt - dc, 1);

    mode = 0;
    kick();
    step(1);
    start = 1'b0;
    chk("j4_err_clr", err, 0);
    step(131);
    chk("j4_done_cnt", done_cnt - dc, 1);
    chk("j4_latency", done_cyc - sc, 131);
    chk("j4_wr_cnt", wr_cnt - wc, 18);
    chk("j4_mem5", wr_mem[5], ref_y(5));
    chk("j4_err", err, 0);

    kick();
    step(1);
    start = 1'b0;
    step(117);
    chk("j5_wb5", {mem_wr_en, mem_addr_wr}, {1'b1, 32'h3005});
    rst = 1'b0;
    #1;
    chk("j5_rst_wr", {mem_wr_en, busy, arr_rst_n}, 0);
    chk("j5_rst_addr", mem_addr_wr, 0);
    step(20);
    chk("j5_words", wr_cnt - wc, 5);
    chk("j5_no_done", done_cnt - dc, 0);
    rst = 1'b1;
    step(5);
    chk("j5_wait_start", busy, 0);

    @(negedge clk);
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    chk("s_rd_w", mem_addr_rd1, 32'h1000);
    step(1);
    chk("s_rd_x", mem_addr_rd1, 32'h2000);
    step(1);
    chk("s_cap", {mem_addr_rd1, 31'b0, arr_rst_n1}, 0);
    step(1);
    chk("s_stream", {X1, W1}, {32'h3, 32'h7});
    step(1);
    chk("s_drain", {X1, W1}, {32'h0, 32'h7});
    step(1);
    chk("s_wr", {mem_wr_en1, mem_addr_wr1}, {1'b1, 32'h3000});
    chk("s_wr_data", mem_data_wr1, 32'h15);
    step(1);
    chk("s_done", {done1, mem_wr_en1}, 2'b10);
    step(1);
    chk("s_idle", {busy1, done1, err1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
